// File: rtl/neuron_pkg.sv
// Shared types, FSM state encoding and int8 activation limits for neuron_act.
package neuron_pkg;

    typedef logic signed [15:0] acc_t;
    typedef logic signed [7:0]  act_t;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        SAT,
        HOLD
    } act_state_e;

    localparam int ACT_MAX = 127;
    localparam int ACT_MIN = -128;

endpackage

// File: rtl/sat_round.sv
// Combinational round-half-up right shift and int8 clamp for neuron_act.
// Build option NEURON_ACT_RELU_EN forces negative results to zero.
module sat_round
    import neuron_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic signed [16:0] sum_i,
    output logic signed [17:0] r18_o,
    input  logic signed [17:0] r18_i,
    output act_t               act_o
);

    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic signed [17:0] HALF  = 18'((1 << SHIFT) >> 1);
    localparam logic signed [17:0] MAX18 = 18'(ACT_MAX);
    localparam logic signed [17:0] MIN18 = 18'(ACT_MIN);

    logic signed [17:0] biased;

    assign biased = signed'({sum_i[16], sum_i}) + HALF;
    assign r18_o  = biased >>> SHIFT;

    always_comb begin
        act_o = act_t'(r18_i[7:0]);
        if (r18_i > MAX18) begin
            act_o = act_t'(ACT_MAX);
        end else if (r18_i < MIN18) begin
            act_o = act_t'(ACT_MIN);
        end
`ifdef NEURON_ACT_RELU_EN
        if (r18_i < 18'sd0) begin
            act_o = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/neuron_act.sv
// Bias add, rounding rescale and int8 saturation of one MAC sum per transaction.
// Build option NEURON_ACT_RELU_EN clamps the activation to [0,127].
module neuron_act
    import neuron_pkg::*;
#(
    parameter int SHIFT = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      acc_in,
    input  logic [15:0]      bias,
    input  logic             acc_valid,
    output logic             acc_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its data unchanged until that edge.

    act_state_e         state_q, state_d;
    logic signed [16:0] sum17_q, sum17_d;
    logic signed [17:0] r18_q, r18_d;
    act_t               data_q, data_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic signed [17:0] r18_rnd;
    act_t               act_sat;

    sat_round #(.SHIFT(SHIFT)) u_sat_round (
        .sum_i (sum17_q),
        .r18_o (r18_rnd),
        .r18_i (r18_q),
        .act_o (act_sat)
    );

    always_comb begin
        state_d = state_q;
        sum17_d = sum17_q;
        r18_d   = r18_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc_valid) begin
                    sum17_d = signed'({acc_in[15], acc_in}) + signed'({bias[15], bias});
                    state_d = SUM;
                end
            end
            SUM: begin
                r18_d   = r18_rnd;
                state_d = SAT;
            end
            SAT: begin
                data_d  = act_sat;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum17_q <= '0;
            r18_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum17_q <= sum17_d;
            r18_q   <= r18_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc_ready = (state_q == IDLE) && !rst;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_neuron_act.sv
// Directed and random checks of neuron_act against a floor-division reference model.
module tb_neuron_act;

    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] acc_in = '0;
    logic [15:0] bias = '0;
    logic        acc_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        acc_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_count;

    logic        acc_ready_w, out_valid_w;
    logic [7:0]  out_data_w;
    logic [2:0]  out_count_w;

    logic [7:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_cnt = 0;

    neuron_act #(.SHIFT(SHIFT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .bias(bias), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count)
    );

    // Narrow-counter copy makes counter wrap reachable in a short run.
    neuron_act #(.SHIFT(SHIFT), .CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .acc_in(acc_in), .bias(bias), .acc_valid(acc_valid),
        .acc_ready(acc_ready_w), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_count(out_count_w)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int model(input int a, input int b);
        int v, d, q;
        v = a + b;
        if (SHIFT > 0) begin
            d = 1 << SHIFT;
            v = v + d / 2;
            q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        end else begin
            q = v;
        end
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`ifdef NEURON_ACT_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: timed out", tag);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int t = 0;
        @(posedge clk); #1;
        acc_in = a;
        bias = b;
        acc_valid = 1'b1;
        exp_q.push_back(8'(model($signed(a), $signed(b))));
        while (!acc_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!acc_ready) timeout("send");
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            timeout("drain");
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) timeout("wait_valid");
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_output: observed %0d expected none", $signed(out_data));
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("out_data", $signed(out_data), $signed(e));
                check("out_data_w", $signed(out_data_w), $signed(e));
                check("out_valid_w", out_valid_w, 1);
                check("out_count", out_count, exp_cnt & 16'hffff);
                check("out_count_w", out_count_w, exp_cnt % 8);
                exp_cnt++;
            end
        end
    end

    int va[8] = '{32767, -32768, 8, 7, -8, -9, -1000, 2047};
    int vb[8] = '{32767, -32768, 0, 0, 0, 0, 0, -40};

    initial begin
        int cnt0;
        logic [15:0] ra, rb;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_acc_ready", acc_ready, 0);
        check("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_acc_ready", acc_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_out_data", out_data, 0);
        check("idle_out_count", out_count, 0);

        // latency: handshake, then two cycles of processing, then valid
        send(16'd1000, 16'd24);
        @(negedge clk);
        check("lat_sum_valid", out_valid, 0);
        @(negedge clk);
        check("lat_sat_valid", out_valid, 0);
        @(negedge clk);
        check("lat_hold_valid", out_valid, 1);
        check("lat_hold_data", $signed(out_data), 64);
        @(negedge clk);
        check("lat_count", out_count, 1);
        check("lat_acc_ready", acc_ready, 1);
        check("lat_valid_clr", out_valid, 0);

        // saturation and rounding corners
        for (int i = 0; i < 8; i++) send(16'(va[i]), 16'(vb[i]));
        drain();

        // random sums
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            send(ra, rb);
        end
        drain();

        // backpressure with ignored acc_valid
        out_ready = 1'b0;
        send(16'd300, 16'd0);
        wait_valid();
        @(posedge clk); #1;
        acc_in = 16'h7fff;
        bias = 16'h1234;
        acc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", $signed(out_data), model(300, 0));
            check("bp_acc_ready", acc_ready, 0);
        end
        cnt0 = exp_cnt;
        @(posedge clk); #1;
        acc_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_count_inc", out_count, (cnt0 + 1) & 16'hffff);
        check("bp_valid_clr", out_valid, 0);
        repeat (3) @(negedge clk);
        check("bp_count_once", out_count, (cnt0 + 1) & 16'hffff);
        check("bp_no_extra", out_valid, 0);

        // reset while in SUM
        send(16'd100, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_sum_acc_ready", acc_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("rst_sum_valid", out_valid, 0);
        check("rst_sum_count", out_count, 0);
        check("rst_sum_acc_ready1", acc_ready, 1);
        repeat (4) @(negedge clk);
        check("rst_sum_discard", out_valid, 0);

        // reset while in HOLD
        send(16'd50, 16'd0);
        drain();
        out_ready = 1'b0;
        send(-16'sd500, 16'd0);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_count", out_count, 0);
        check("rst_hold_acc_ready", acc_ready, 1);

        // counter wrap on the narrow copy
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom_range(0, 65535));
            send(ra, 16'd0);
        end
        drain();
        @(negedge clk);
        check("wrap_count", out_count, exp_cnt & 16'hffff);
        check("wrap_count_w", out_count_w, exp_cnt % 8);
        check("wrap_acc_ready_w", acc_ready_w, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
